clock_set_controller: RTL and testbench

CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

---
 rtl/clock_ctrl_pkg.sv | 31 +++
 rtl/btn_debounce.sv | 57 +++++
 rtl/clock_set_controller.sv | 161 ++++++++++++++++
 tb/tb_clock_set_controller.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// rtl/clock_ctrl_pkg.sv - shared mode encoding, default timing constants and helpers for the clock-set controller
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HR   = 2'd1,
    SET_MIN  = 2'd2,
    SET_AMPM = 2'd3
  } mode_t;

  localparam int DEF_DB_CYCLES     = 1_000_000;
  localparam int DEF_TIMEOUT_S     = 30;
  localparam int DEF_HOLD_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 25_000_000;

  // Bits needed for a counter that must hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  // Mode button walks the set states in display order and wraps back to RUN.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      RUN:     return SET_HR;
      SET_HR:  return SET_MIN;
      SET_MIN: return SET_AMPM;
      default: return RUN;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, stable-window debouncer and rising-edge press pulse for one button
module btn_debounce
  import clock_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int             CW      = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);

  logic          sync0_q, sync1_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level flips only after DB_CYCLES consecutive synchronized samples disagree with it.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync1_q != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = sync1_q;
        press_d = sync1_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, window counter, debounced level and press pulse registers.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync0_q <= btn_i;
      sync1_q <= sync0_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - clock-setting mode FSM with increment strobes; CLOCK_SET_AUTO_REPEAT_EN adds up-button auto-repeat
module clock_set_controller
  import clock_ctrl_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int TIMEOUT_S     = DEF_TIMEOUT_S,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       tick_1Hz,
  output logic [1:0] set_mode,
  output logic       inc_hr,
  output logic       inc_min,
  output logic       toggle_am_pm,
  output logic       sec_clear,
  output logic       blink
);

  localparam int            IW       = cnt_width(TIMEOUT_S);
  localparam logic [IW-1:0] IDLE_PRE = IW'(TIMEOUT_S - 1);

  mode_t         state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          tick_q;
  logic          inc_hr_q, inc_hr_d, inc_min_q, inc_min_d, tog_q, tog_d;
  logic          blink_q, blink_d;
  logic          mode_press, up_press, mode_level, up_level;
  logic          in_set, tick_rise, timeout, rep_strobe;
  logic          unused_levels;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_mode_db (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn_i(btn_mode),
    .level_o(mode_level), .press_o(mode_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_up_db (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn_i(btn_up),
    .level_o(up_level), .press_o(up_press)
  );

  assign in_set    = (state_q != RUN);
  assign tick_rise = tick_1Hz & ~tick_q;
  // A press in the same cycle restarts the idle window, so it beats the timeout.
  assign timeout   = in_set && !mode_press && !up_press && tick_rise && (idle_q == IDLE_PRE);

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam int RW = cnt_width((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
  localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_first_q, rep_first_d, rep_armed_q, rep_armed_d;

  // Armed by an up press in a set state; disarmed by release, mode change or timeout.
  always_comb begin
    rep_cnt_d   = '0;
    rep_first_d = 1'b1;
    rep_armed_d = 1'b0;
    rep_strobe  = 1'b0;
    if (in_set && !mode_press && !timeout) begin
      if (up_press) begin
        rep_armed_d = 1'b1;
      end else if (rep_armed_q && up_level) begin
        rep_armed_d = 1'b1;
        if (rep_cnt_q == (rep_first_q ? HOLD_LAST : REP_LAST)) begin
          rep_strobe  = 1'b1;
          rep_first_d = 1'b0;
        end else begin
          rep_cnt_d   = rep_cnt_q + 1'b1;
          rep_first_d = rep_first_q;
        end
      end
    end
  end

  // Auto-repeat hold/period counter registers.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      rep_armed_q <= rep_armed_d;
    end
  end

  assign unused_levels = mode_level;
`else
  localparam int unused_repeat_params = HOLD_CYCLES + REPEAT_CYCLES;

  assign rep_strobe    = 1'b0;
  assign unused_levels = mode_level ^ up_level;
`endif

  // Next mode, idle seconds and the strobe for the field being set; mode press wins over up.
  always_comb begin
    state_d   = state_q;
    idle_d    = idle_q;
    inc_hr_d  = 1'b0;
    inc_min_d = 1'b0;
    tog_d     = 1'b0;
    if (mode_press) begin
      state_d = next_mode(state_q);
      idle_d  = '0;
    end else if (in_set) begin
      if (timeout) begin
        state_d = RUN;
        idle_d  = '0;
      end else begin
        if (up_press) begin
          idle_d = '0;
        end else if (tick_rise) begin
          idle_d = idle_q + 1'b1;
        end
        if (up_press || rep_strobe) begin
          case (state_q)
            SET_HR:  inc_hr_d  = 1'b1;
            SET_MIN: inc_min_d = 1'b1;
            default: tog_d     = 1'b1;
          endcase
        end
      end
    end
    blink_d = (state_d == RUN) ? 1'b1 : tick_1Hz;
  end

  // State, idle counter, tick edge detector and registered outputs.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      idle_q    <= '0;
      tick_q    <= 1'b0;
      inc_hr_q  <= 1'b0;
      inc_min_q <= 1'b0;
      tog_q     <= 1'b0;
      blink_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      idle_q    <= idle_d;
      tick_q    <= tick_1Hz;
      inc_hr_q  <= inc_hr_d;
      inc_min_q <= inc_min_d;
      tog_q     <= tog_d;
      blink_q   <= blink_d;
    end
  end

  assign set_mode     = state_q;
  assign inc_hr       = inc_hr_q;
  assign inc_min      = inc_min_q;
  assign sec_clear    = inc_min_q;
  assign toggle_am_pm = tog_q;
  assign blink        = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// tb/tb_clock_set_controller.sv - self-checking bench for clock_set_controller against a behavioural model
module tb_clock_set_controller;

  localparam int DB   = 4;
  localparam int TO   = 3;
  localparam int HOLD = 20;
  localparam int REP  = 8;

  logic       clk_100MHz = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       tick_1Hz = 1'b0;
  logic [1:0] set_mode;
  logic       inc_hr, inc_min, toggle_am_pm, sec_clear, blink;

  int tests_run = 0;
  int fails = 0;
  int c_hr = 0, c_min = 0, c_tog = 0, c_sec = 0, c_coinc = 0;

  clock_set_controller #(
    .DB_CYCLES(DB), .TIMEOUT_S(TO), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up),
    .tick_1Hz(tick_1Hz), .set_mode(set_mode), .inc_hr(inc_hr), .inc_min(inc_min),
    .toggle_am_pm(toggle_am_pm), .sec_clear(sec_clear), .blink(blink)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  wire [5:0] dut_out = {set_mode, inc_hr, inc_min, toggle_am_pm, sec_clear, blink};

  // Reference model state: mode number, idle seconds, cycles held since an up press (-1 none).
  int       m_mode, m_idle, m_held;
  bit       m_tick_prev, m_mlvl, m_ulvl, m_mpress, m_upress;
  bit       mh[$];
  bit       uh[$];
  bit [5:0] m_out;

  // True when the DB synchronized samples (raw delayed two clocks) all equal v.
  function automatic bit settled(input bit h[$], input bit v);
    for (int i = 0; i < DB; i++)
      if (h[h.size() - 3 - i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_idle = 0; m_held = -1; m_tick_prev = 1'b0;
    m_mlvl = 1'b0; m_ulvl = 1'b0; m_mpress = 1'b0; m_upress = 1'b0;
    mh.delete(); uh.delete();
    for (int i = 0; i < DB + 2; i++) begin mh.push_back(1'b0); uh.push_back(1'b0); end
    m_out = 6'b000001;
  endtask

  task automatic model_edge();
    bit rise, strobe;
    int nm, old;
    mh.push_back(btn_mode); uh.push_back(btn_up);
    while (mh.size() > 16) void'(mh.pop_front());
    while (uh.size() > 16) void'(uh.pop_front());
    rise = tick_1Hz && !m_tick_prev;
    strobe = 1'b0; old = m_mode; nm = m_mode;
    if (m_mpress) begin
      nm = (m_mode + 1) % 4; m_idle = 0; m_held = -1;
    end else if (m_mode != 0) begin
      if (!m_upress && rise && m_idle == TO - 1) begin
        nm = 0; m_idle = 0; m_held = -1;
      end else if (m_upress) begin
        m_idle = 0; strobe = 1'b1; m_held = 0;
      end else begin
        if (rise) m_idle++;
        if (m_held >= 0 && m_ulvl) begin
          m_held++;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
          if (m_held >= HOLD && (m_held - HOLD) % REP == 0) strobe = 1'b1;
`endif
        end else begin
          m_held = -1;
        end
      end
    end
    m_out = {2'(nm), strobe && old == 1, strobe && old == 2, strobe && old == 3,
             strobe && old == 2, (nm == 0) ? 1'b1 : tick_1Hz};
    m_mode = nm;
    m_mpress = 1'b0; m_upress = 1'b0;
    if (!m_mlvl && settled(mh, 1'b1)) begin m_mlvl = 1'b1; m_mpress = 1'b1; end
    else if (m_mlvl && settled(mh, 1'b0)) m_mlvl = 1'b0;
    if (!m_ulvl && settled(uh, 1'b1)) begin m_ulvl = 1'b1; m_upress = 1'b1; end
    else if (m_ulvl && settled(uh, 1'b0)) m_ulvl = 1'b0;
    m_tick_prev = tick_1Hz;
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    if (reset) model_reset(); else model_edge();
    #1;
    if (inc_hr) c_hr++;
    if (inc_min) c_min++;
    if (toggle_am_pm) c_tog++;
    if (sec_clear) c_sec++;
    if (inc_min && sec_clear) c_coinc++;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; repeat (10) step();
    btn_mode = 1'b0; repeat (10) step();
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) begin
      step();
      tests_run++;
      if (dut_out !== 6'b000001) begin fails++; $display("FAIL reset_state: got %b want %b", dut_out, 6'b000001); end
    end
    reset = 1'b0;
    repeat (5) begin
      step();
      tests_run++;
      if (dut_out !== m_out) begin fails++; $display("FAIL reset_idle: got %b want %b", dut_out, m_out); end
    end
  endtask

  task automatic test_mode_cycle();
    int s0, lat;
    s0 = c_hr + c_min + c_tog + c_sec;
    for (int p = 0; p < 4; p++) begin
      lat = -1;
      btn_mode = 1'b1;
      for (int c = 1; c <= 20; c++) begin
        if (c == 11) btn_mode = 1'b0;
        step();
        tests_run++;
        if (dut_out !== m_out) begin fails++; $display("FAIL mode_cycle: got %b want %b", dut_out, m_out); end
        if (lat < 0 && set_mode == 2'((p + 1) % 4)) lat = c;
      end
      tests_run++;
      if (set_mode !== 2'((p + 1) % 4)) begin fails++; $display("FAIL mode_value: got %0d want %0d", set_mode, (p + 1) % 4); end
      tests_run++;
      if (lat != 2 + DB + 1) begin fails++; $display("FAIL mode_latency: got %0d want %0d", lat, 2 + DB + 1); end
    end
    tests_run++;
    if (c_hr + c_min + c_tog + c_sec != s0) begin fails++; $display("FAIL mode_no_strobe: got %0d want %0d", c_hr + c_min + c_tog + c_sec, s0); end
  endtask

  task automatic test_glitch();
    int m0, s0, k0;
    press_mode(); press_mode();
    m0 = c_min; s0 = c_sec; k0 = c_coinc;
    for (int g = 0; g < 5; g++) begin
      btn_up = 1'b1; step();
      tests_run++;
      if (dut_out !== m_out) begin fails++; $display("FAIL glitch_pulse: got %b want %b", dut_out, m_out); end
      btn_up = 1'b0; step();
      tests_run++;
      if (dut_out !== m_out) begin fails++; $display("FAIL glitch_pulse: got %b want %b", dut_out, m_out); end
    end
    btn_up = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) btn_up = 1'b0;
      step();
      tests_run++;
      if (dut_out !== m_out) begin fails++; $display("FAIL glitch_hold: got %b want %b", dut_out, m_out); end
    end
    tests_run++;
    if (c_min - m0 != 1) begin fails++; $display("FAIL glitch_inc_min: got %0d want 1", c_min - m0); end
    tests_run++;
    if (c_sec - s0 != 1 || c_coinc - k0 != 1) begin fails++; $display("FAIL glitch_sec_clear: got %0d/%0d want 1/1", c_sec - s0, c_coinc - k0); end
    press_mode(); press_mode();
  endtask

  task automatic test_timeout();
    int s0;
    press_mode();
    s0 = c_hr + c_min + c_tog;
    for (int r = 1; r <= 3; r++) begin
      tick_1Hz = 1'b0;
      repeat (2) begin
        step();
        tests_run++;
        if (dut_out !== m_out) begin fails++; $display("FAIL timeout_track: got %b want %b", dut_out, m_out); end
      end
      tests_run++;
      if (set_mode !== 2'd1) begin fails++; $display("FAIL timeout_early: got %0d want 1", set_mode); end
      tick_1Hz = 1'b1;
      step();
      tests_run++;
      if (set_mode !== ((r == 3) ? 2'd0 : 2'd1)) begin fails++; $display("FAIL timeout_exit: rise %0d got %0d want %0d", r, set_mode, (r == 3) ? 0 : 1); end
      step();
      tests_run++;
      if (dut_out !== m_out) begin fails++; $display("FAIL timeout_track: got %b want %b", dut_out, m_out); end
    end
    tick_1Hz = 1'b0;
    step();
    tests_run++;
    if (c_hr + c_min + c_tog != s0) begin fails++; $display("FAIL timeout_strobes: got %0d want %0d", c_hr + c_min + c_tog - s0, 0); end
  endtask

  task automatic test_simultaneous();
    int h0;
    press_mode();
    h0 = c_hr;
    btn_mode = 1'b1; btn_up = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) begin btn_mode = 1'b0; btn_up = 1'b0; end
      step();
      tests_run++;
      if (dut_out !== m_out) begin fails++; $display("FAIL simul_track: got %b want %b", dut_out, m_out); end
    end
    tests_run++;
    if (set_mode !== 2'd2) begin fails++; $display("FAIL simul_mode: got %0d want 2", set_mode); end
    tests_run++;
    if (c_hr != h0) begin fails++; $display("FAIL simul_no_inc_hr: got %0d want 0", c_hr - h0); end
    press_mode(); press_mode();
  endtask

  task automatic test_hold();
    int h0, expv;
    press_mode();
    h0 = c_hr;
    btn_up = 1'b1;
    for (int c = 0; c < 75; c++) begin
      if (c == 60) btn_up = 1'b0;
      step();
      tests_run++;
      if (dut_out !== m_out) begin fails++; $display("FAIL hold_track: got %b want %b", dut_out, m_out); end
    end
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    expv = 1 + 1 + (60 - 1 - HOLD) / REP;
`else
    expv = 1;
`endif
    tests_run++;
    if (c_hr - h0 != expv) begin fails++; $display("FAIL hold_inc_hr: got %0d want %0d", c_hr - h0, expv); end
    press_mode(); press_mode(); press_mode();
  endtask

  task automatic test_reset_mid_press();
    int t0;
    press_mode(); press_mode(); press_mode();
    t0 = c_tog;
    btn_up = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    model_reset();
    #1;
    tests_run++;
    if (dut_out !== 6'b000001) begin fails++; $display("FAIL reset_async: got %b want %b", dut_out, 6'b000001); end
    repeat (3) step();
    reset = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (c == 15) btn_up = 1'b0;
      step();
      tests_run++;
      if (dut_out !== m_out) begin fails++; $display("FAIL reset_mid_track: got %b want %b", dut_out, m_out); end
    end
    tests_run++;
    if (c_tog != t0) begin fails++; $display("FAIL reset_mid_toggle: got %0d want 0", c_tog - t0); end
  endtask

  task automatic test_random();
    int tcnt;
    tcnt = 5;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 11) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 7) == 0) btn_up = ~btn_up;
      if (tcnt == 0) begin tick_1Hz = ~tick_1Hz; tcnt = $urandom_range(3, 25); end
      else tcnt--;
      step();
      tests_run++;
      if (dut_out !== m_out) begin fails++; $display("FAIL random: cycle %0d got %b want %b", c, dut_out, m_out); end
      tests_run++;
      if (32'(inc_hr) + 32'(inc_min) + 32'(toggle_am_pm) > 1) begin fails++; $display("FAIL random_onehot: cycle %0d got %b want at most one", c, {inc_hr, inc_min, toggle_am_pm}); end
    end
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_glitch();
    test_timeout();
    test_simultaneous();
    test_hold();
    test_reset_mid_press();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
